// File: rtl/greyscale_converter_if.sv
// Fetch handshake with AHB_wrapper plus the grey pixel stream toward the edge-detection line buffer.
// The converter side is the master: it issues re and drives the pixel outputs.
interface greyscale_converter_if;
    logic [31:0] greyscale_data;
    logic        read_complete;
    logic        re;
    logic        buffer_full;
    logic [7:0]  grey_pixel;
    logic        grey_valid;

    modport master (
        input  greyscale_data, read_complete, buffer_full,
        output re, grey_pixel, grey_valid
    );

    modport slave (
        output greyscale_data, read_complete, buffer_full,
        input  re, grey_pixel, grey_valid
    );
endinterface

// File: rtl/greyscale_converter.sv
// Unpacks a contiguous BGR byte stream from 32-bit fetched words and emits one 8-bit grey value per pixel.
// A 6-byte store decouples word arrival from pixel consumption; at most one word request is outstanding.
module greyscale_converter #(
    parameter int CNT_W = 20
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_pixels,
    greyscale_converter_if.master bus,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0][7:0]  store_q, store_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] pixels_left_q, pixels_left_d;
    logic             re_q, re_d;
    logic [7:0]       grey_pixel_q, grey_pixel_d;
    logic             grey_valid_q, grey_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    // Byte idx of a fetched word in stream order; byte 0 is the most significant.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = word[31:24];
            3'd1:    b = word[23:16];
            3'd2:    b = word[15:8];
            3'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Weights sum to 256, so the 16-bit sum cannot overflow and the top byte is the truncated result.
    function automatic logic [7:0] grey_of(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        logic [15:0] acc;
        acc = (16'd77 * {8'h00, r}) + (16'd150 * {8'h00, g}) + (16'd29 * {8'h00, b});
        return acc[15:8];
    endfunction

    // Next-state, byte store and output computation.
    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        cnt_d         = cnt_q;
        pixels_left_d = pixels_left_q;
        grey_pixel_d  = grey_pixel_q;
        grey_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pixels_left_d = num_pixels;
                    cnt_d         = 3'd0;
                    state_d       = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (pixels_left_q == {CNT_W{1'b0}}) begin
                    state_d = DONE;
                end else if ((cnt_q >= 3'd3) && !bus.buffer_full) begin
                    grey_pixel_d  = grey_of(store_q[0], store_q[1], store_q[2]);
                    grey_valid_d  = 1'b1;
                    store_d       = {24'h000000, store_q[5:3]};
                    cnt_d         = cnt_q - 3'd3;
                    pixels_left_d = pixels_left_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (cnt_q < 3'd3) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (bus.read_complete) begin
                    // WAIT is only entered with cnt<=2, so the four new bytes always fit in slots cnt..cnt+3.
                    for (int j = 0; j < 6; j++) begin
                        if ((3'(j) >= cnt_q) && ({1'b0, 3'(j)} < ({1'b0, cnt_q} + 4'd4))) begin
                            store_d[j] = word_byte(bus.greyscale_data, 3'(j) - cnt_q);
                        end else begin
                            store_d[j] = store_q[j];
                        end
                    end
                    cnt_d   = cnt_q + 3'd4;
                    state_d = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                store_d = 48'h0;
                cnt_d   = 3'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A RUN cycle with fewer than 3 bytes and pixels still owed always moves to WAIT, so re is
        // decided one edge early and is high exactly during that RUN cycle.
        re_d         = (state_d == RUN) && (cnt_d < 3'd3) && (pixels_left_d != {CNT_W{1'b0}});
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            store_q       <= 48'h0;
            cnt_q         <= 3'd0;
            pixels_left_q <= {CNT_W{1'b0}};
            re_q          <= 1'b0;
            grey_pixel_q  <= 8'h00;
            grey_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            cnt_q         <= cnt_d;
            pixels_left_q <= pixels_left_d;
            re_q          <= re_d;
            grey_pixel_q  <= grey_pixel_d;
            grey_valid_q  <= grey_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.re         = re_q;
    assign bus.grey_pixel = grey_pixel_q;
    assign bus.grey_valid = grey_valid_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_greyscale_converter.sv
// Scoreboard bench: expected grey pixels are queued as frames are set up, a monitor pops on grey_valid,
// and a responder process plays the AHB_wrapper side, answering each re with the next queued word.
module tb_greyscale_converter;
    localparam int CNT_W = 20;
    localparam int NRAND = 1000;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [CNT_W-1:0] num_pixels;
    logic             busy;
    logic             frame_done;

    greyscale_converter_if bus();

    greyscale_converter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .num_pixels (num_pixels),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    logic [31:0] word_q[$];
    int          gv_cyc_q[$];
    logic [7:0]  rb[NRAND*3];

    int n_vec = 0;
    int n_err = 0;
    int re_count = 0;
    int fd_count = 0;
    int gv_count = 0;
    int cyc = 0;
    int last_gv_cyc = -1;
    int rsp_cd = 0;
    bit hold_rsp = 1'b0;
    bit inj_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] grey_ref(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s / 256);
    endfunction

    // Monitor: samples outputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.grey_valid) begin
                check("stall_emit", {31'd0, bus.buffer_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pixel_extra: got %0h, expected no pixel", bus.grey_pixel);
                end else begin
                    check("pixel", {24'd0, bus.grey_pixel}, {24'd0, exp_q.pop_front()});
                end
                last_gv_cyc = cyc;
                gv_cyc_q.push_back(cyc);
                gv_count++;
            end
            if (frame_done) begin
                fd_count++;
                check("frame_leftover", exp_q.size(), 32'd0);
                if (last_gv_cyc >= 0) check("done_gap", cyc - last_gv_cyc, 32'd1);
                last_gv_cyc = -1;
            end
        end
    end

    // AHB_wrapper model: answers each re after 1..3 cycles, or injects a stray read_complete on request.
    initial begin
        bus.read_complete  = 1'b0;
        bus.greyscale_data = 32'h0;
        forever begin
            @(negedge clk);
            bus.read_complete = 1'b0;
            if (!n_rst) begin
                rsp_cd = 0;
            end else if (rsp_cd > 0) begin
                if (!hold_rsp) begin
                    rsp_cd--;
                    if (rsp_cd == 0) begin
                        bus.read_complete  = 1'b1;
                        bus.greyscale_data = (word_q.size() > 0) ? word_q.pop_front() : 32'h0;
                    end
                end
            end else if (inj_req) begin
                bus.read_complete  = 1'b1;
                bus.greyscale_data = 32'hDEADBEEF;
                inj_req            = 1'b0;
            end
            if (bus.re) begin
                re_count++;
                if (rsp_cd != 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL re_outstanding: got re with %0d cycles of response pending, expected none", rsp_cd);
                end
                rsp_cd = int'($urandom_range(3, 1));
            end
        end
    end

    task automatic do_start(input int np);
        @(negedge clk);
        num_pixels = CNT_W'(np);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int fd0;
        int k;
        fd0 = fd_count;
        k   = 0;
        while (fd_count == fd0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fd_count == fd0) begin
            n_err++;
            $display("FAIL %s_timeout: got no frame_done in %0d cycles, expected one", name, budget);
        end
        n_vec++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by 2 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int re0;
        int g0;
        int k;
        int fd0;

        n_rst           = 1'b0;
        start           = 1'b0;
        num_pixels      = '0;
        bus.buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_re", {31'd0, bus.re}, 32'd0);
        check("rst_gv", {31'd0, bus.grey_valid}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel: B=10 G=20 R=30 -> (77*0x30+150*0x20+29*0x10)>>8 = 8960>>8 = 0x23
        word_q.push_back(32'h102030AB);
        exp_q.push_back(8'h23);
        re0 = re_count;
        do_start(1);
        wait_done("single", 100);
        check("single_re", re_count - re0, 32'd1);
        check("single_idle", {31'd0, busy}, 32'd0);

        // Alignment: 3 words carry exactly 4 pixels
        word_q.push_back(32'hFFFFFF00);
        word_q.push_back(32'h00001020);
        word_q.push_back(32'h30FFFFFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h23); exp_q.push_back(8'hFF);
        re0 = re_count;
        do_start(4);
        wait_done("align", 200);
        check("align_re", re_count - re0, 32'd3);

        // Stall with 6 bytes stored; stray start and read_complete while RUN must do nothing
        word_q.push_back(32'hFFFFFF00);
        word_q.push_back(32'h00001020);
        word_q.push_back(32'h30FFFFFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h23); exp_q.push_back(8'hFF);
        re0 = re_count;
        do_start(4);
        k = 0;
        while (re_count < re0 + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_third_re", re_count - re0, 32'd3);
        bus.buffer_full = 1'b1;
        g0  = gv_count;
        re0 = re_count;
        repeat (5) @(negedge clk);
        num_pixels = CNT_W'(7);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        inj_req    = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_gv", gv_count - g0, 32'd0);
        check("stall_re", re_count - re0, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        bus.buffer_full = 1'b0;
        wait_done("stall", 100);
        check("stall_back2back", gv_cyc_q[gv_cyc_q.size()-1] - gv_cyc_q[gv_cyc_q.size()-2], 32'd1);
        check("stall_pixels", gv_count - g0, 32'd2);

        // Empty frame
        re0 = re_count;
        do_start(0);
        wait_done("zero", 50);
        check("zero_re", re_count - re0, 32'd0);
        check("zero_idle", {31'd0, busy}, 32'd0);

        // Reset while waiting for a word
        hold_rsp = 1'b1;
        fd0 = fd_count;
        do_start(1);
        repeat (4) @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("abort_re", {31'd0, bus.re}, 32'd0);
        check("abort_gv", {31'd0, bus.grey_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_fd", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst    = 1'b1;
        hold_rsp = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_no_fd", fd_count - fd0, 32'd0);

        // Clean frame after abort: all bytes 0x80 -> 0x80
        word_q.push_back(32'h80808000);
        exp_q.push_back(8'h80);
        re0 = re_count;
        do_start(1);
        wait_done("restart", 100);
        check("restart_re", re_count - re0, 32'd1);

        // Random frame against the reference model
        for (int i = 0; i < NRAND * 3; i++) rb[i] = 8'($urandom_range(255, 0));
        for (int p = 0; p < NRAND; p++) exp_q.push_back(grey_ref(rb[3*p], rb[3*p+1], rb[3*p+2]));
        for (int w = 0; w < NRAND * 3 / 4; w++) word_q.push_back({rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]});
        re0 = re_count;
        g0  = gv_count;
        do_start(NRAND);
        wait_done("random", 20000);
        check("random_re", re_count - re0, 32'd750);
        check("random_pixels", gv_count - g0, 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
